// File: rtl/bpsk_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// bpsk_tx_ctrl_if : byte handshake and modulator-control bundle for bpsk_tx_ctrl
// Rev 1.0 - initial release
// ============================================================================
interface bpsk_tx_ctrl_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       mod_en;
    logic       mod_s;
    logic       busy;
    logic       bit_strobe;
    logic       frame_done;

    modport master (
        output data_in, data_valid,
        input  data_ready, mod_en, mod_s, busy, bit_strobe, frame_done
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, mod_en, mod_s, busy, bit_strobe, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/bpsk_tx_ctrl.sv
`default_nettype none
// ============================================================================
// bpsk_tx_ctrl : preamble framing and carrier-synchronous bit timing for BPSK
// Rev 1.0 - initial release
// ============================================================================
module bpsk_tx_ctrl #(
    parameter int          ADDR_WIDTH   = 8,
    parameter int          PREAMBLE_LEN = 8,
    parameter logic [31:0] PREAMBLE     = 32'hAAAAAAAA
) (
    input  wire            clk,
    input  wire            arst,
    bpsk_tx_ctrl_if.slave  io_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [4:0]            c_pre_last = 5'(PREAMBLE_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] c_cnt_max  = '1;
    localparam logic [ADDR_WIDTH-1:0] c_cnt_one  = ADDR_WIDTH'(1);

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [4:0]            r_pre_idx, w_pre_idx_nxt, w_pre_dec;
    logic [2:0]            r_bit_idx, w_bit_idx_nxt;
    logic [7:0]            r_sh, w_sh_nxt;
    logic                  r_mod_s, w_mod_s_nxt;
    logic                  r_frame_done, w_frame_done_nxt;
    logic                  w_wrap, w_ready, w_xfer;

    // Every decision is taken on the carrier wrap so bit edges hit zero crossings.
    assign w_wrap    = (r_cnt == c_cnt_max);
    assign w_ready   = w_wrap && !arst &&
                       ((r_state == S_IDLE) || ((r_state == S_DATA) && (r_bit_idx == 3'd7)));
    assign w_xfer    = w_ready && io_bus.data_valid;
    assign w_pre_dec = r_pre_idx - 5'd1;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_cnt        <= '0;
            r_state      <= S_IDLE;
            r_pre_idx    <= '0;
            r_bit_idx    <= '0;
            r_sh         <= '0;
            r_mod_s      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= r_cnt + c_cnt_one;
            r_state      <= w_state_nxt;
            r_pre_idx    <= w_pre_idx_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_sh         <= w_sh_nxt;
            r_mod_s      <= w_mod_s_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pre_idx_nxt    = r_pre_idx;
        w_bit_idx_nxt    = r_bit_idx;
        w_sh_nxt         = r_sh;
        w_mod_s_nxt      = r_mod_s;
        w_frame_done_nxt = 1'b0;
        if (w_wrap) begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        w_state_nxt   = S_PRE;
                        w_pre_idx_nxt = c_pre_last;
                        w_sh_nxt      = io_bus.data_in;
                        w_mod_s_nxt   = PREAMBLE[c_pre_last];
                    end
                end
                S_PRE: begin
                    // The byte is shifted out of the top of r_sh one bit per period.
                    if (r_pre_idx == 5'd0) begin
                        w_state_nxt   = S_DATA;
                        w_bit_idx_nxt = 3'd0;
                        w_mod_s_nxt   = r_sh[7];
                        w_sh_nxt      = {r_sh[6:0], 1'b0};
                    end else begin
                        w_pre_idx_nxt = w_pre_dec;
                        w_mod_s_nxt   = PREAMBLE[w_pre_dec];
                    end
                end
                S_DATA: begin
                    if (r_bit_idx == 3'd7) begin
                        if (w_xfer) begin
                            w_bit_idx_nxt = 3'd0;
                            w_mod_s_nxt   = io_bus.data_in[7];
                            w_sh_nxt      = {io_bus.data_in[6:0], 1'b0};
                        end else begin
                            w_state_nxt      = S_IDLE;
                            w_frame_done_nxt = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_mod_s_nxt   = r_sh[7];
                        w_sh_nxt      = {r_sh[6:0], 1'b0};
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign io_bus.data_ready = w_ready;
    assign io_bus.mod_en     = (r_state != S_IDLE);
    assign io_bus.busy       = (r_state != S_IDLE);
    assign io_bus.mod_s      = r_mod_s;
    assign io_bus.bit_strobe = (r_cnt == '0) && (r_state != S_IDLE);
    assign io_bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_tx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bpsk_tx_ctrl : vector table, corner sequences and random traffic against
//                   a bit-list reference model of the framing controller
// Rev 1.0 - initial release
// ============================================================================
module tb_bpsk_tx_ctrl;

    localparam int SPB = 4; // samples per bit with ADDR_WIDTH = 2

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    bpsk_tx_ctrl_if u_if ();
    bpsk_tx_ctrl_if u_if2 ();

    bpsk_tx_ctrl #(.ADDR_WIDTH(2), .PREAMBLE_LEN(8), .PREAMBLE(32'h000000AA)) u_dut (
        .clk    (clk),
        .arst   (arst),
        .io_bus (u_if)
    );

    bpsk_tx_ctrl #(.ADDR_WIDTH(2), .PREAMBLE_LEN(1), .PREAMBLE(32'h00000001)) u_dut2 (
        .clk    (clk),
        .arst   (arst),
        .io_bus (u_if2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the frame is a list of bits, each lasting SPB samples.
    int         m_cycle;
    bit         m_active;
    bit         m_done;
    bit         m_last_s;
    int         m_k;
    bit         m_bits[$];
    logic [7:0] m_pre = 8'hAA;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          nbytes;
        int          exp_en;
        logic [31:0] exp_pat;
        int          exp_strobes;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) m_bits.push_back(b[i]);
    endtask

    // Inputs for this cycle are already driven; advances one clock and checks.
    task automatic tick(output bit x);
        bit         exp_rdy;
        logic [4:0] exp_o, got_o;
        exp_rdy = ((m_cycle % SPB) == SPB - 1) &&
                  (!m_active || ((m_k / SPB) == m_bits.size() - 1));
        if (!arst) check("data_ready", {31'd0, u_if.data_ready}, {31'd0, exp_rdy});
        x = !arst && u_if.data_valid && exp_rdy;
        if (arst) begin
            m_cycle = 0; m_active = 0; m_done = 0; m_last_s = 0; m_k = 0;
            m_bits.delete();
        end else begin
            m_done = 0;
            m_cycle++;
            if (!m_active) begin
                if (x) begin
                    m_bits.delete();
                    for (int i = 7; i >= 0; i--) m_bits.push_back(m_pre[i]);
                    push_byte(u_if.data_in);
                    m_k = 0;
                    m_active = 1;
                end
            end else begin
                m_k++;
                if (m_k == m_bits.size() * SPB) begin
                    if (x) push_byte(u_if.data_in);
                    else begin
                        m_last_s = m_bits[m_bits.size() - 1];
                        m_active = 0;
                        m_done   = 1;
                        m_bits.delete();
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        exp_o = {m_active, m_active ? m_bits[m_k / SPB] : m_last_s, m_active,
                 m_active && ((m_cycle % SPB) == 0), m_done};
        got_o = {u_if.mod_en, u_if.mod_s, u_if.busy, u_if.bit_strobe, u_if.frame_done};
        check("outputs{en,s,busy,strobe,done}", {27'd0, got_o}, {27'd0, exp_o});
    endtask

    task automatic align(input int phase);
        bit x;
        for (int i = 0; i < SPB && (m_cycle % SPB) != phase; i++) tick(x);
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                             output int en_cyc, output logic [31:0] pat,
                             output int strobes, output int dones);
        bit x;
        int guard;
        en_cyc = 0; pat = '0; strobes = 0; dones = 0; guard = 0;
        u_if.data_in = b0;
        u_if.data_valid = 1'b1;
        do begin
            tick(x);
            guard++;
        end while (!x && guard < 16);
        if (!x) check("accept_timeout", 32'd0, 32'd1);
        if (nbytes > 1) u_if.data_in = b1;
        else            u_if.data_valid = 1'b0;
        guard = 0;
        while (u_if.mod_en && guard < 400) begin
            en_cyc++;
            if (u_if.bit_strobe) begin
                strobes++;
                pat = {pat[30:0], u_if.mod_s};
            end
            dones += int'(u_if.frame_done);
            tick(x);
            if (x) u_if.data_valid = 1'b0;
            guard++;
        end
        dones += int'(u_if.frame_done);
        u_if.data_valid = 1'b0;
    endtask

    initial begin
        vec_t        vecs[4];
        bit          x;
        int          en_cyc, strobes, dones, nx, guard;
        logic [31:0] pat;
        logic [3:0]  rpat;
        logic [8:0]  pat9;

        vecs[0] = '{8'hC5, 8'h00, 1, 64, 32'h0000AAC5, 16};
        vecs[1] = '{8'h00, 8'hFF, 2, 96, 32'h00AA00FF, 24};
        vecs[2] = '{8'h5A, 8'h00, 1, 64, 32'h0000AA5A, 16};
        vecs[3] = '{8'h3C, 8'h81, 2, 96, 32'h00AA3C81, 24};

        m_cycle = 0; m_active = 0; m_done = 0; m_last_s = 0; m_k = 0;
        arst = 1'b1;
        u_if.data_in = '0;   u_if.data_valid = 1'b0;
        u_if2.data_in = '0;  u_if2.data_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick(x);
        arst = 1'b0;
        check("reset_outputs",
              {26'd0, u_if.data_ready, u_if.mod_en, u_if.mod_s, u_if.busy, u_if.bit_strobe, u_if.frame_done},
              32'd0);

        // Single and back-to-back frames, valid raised at cnt == 1.
        foreach (vecs[v]) begin
            align(1);
            run_frame(vecs[v].b0, vecs[v].b1, vecs[v].nbytes, en_cyc, pat, strobes, dones);
            check($sformatf("vec%0d_en_cycles", v), en_cyc, vecs[v].exp_en);
            check($sformatf("vec%0d_bits", v), pat, vecs[v].exp_pat);
            check($sformatf("vec%0d_strobes", v), strobes, vecs[v].exp_strobes);
            check($sformatf("vec%0d_frame_done", v), dones, 1);
            tick(x);
        end

        // Valid held for 10 idle cycles with data changing each cycle.
        align(0);
        nx = 0; pat = '0;
        for (int i = 0; i < 10; i++) begin
            u_if.data_in = 8'h10 + 8'(i);
            u_if.data_valid = 1'b1;
            if (u_if.data_ready) nx++;
            tick(x);
            if (u_if.bit_strobe) pat = {pat[30:0], u_if.mod_s};
        end
        u_if.data_valid = 1'b0;
        guard = 0;
        while (u_if.mod_en && guard < 200) begin
            tick(x);
            if (u_if.bit_strobe) pat = {pat[30:0], u_if.mod_s};
            guard++;
        end
        check("held_valid_transfers", nx, 1);
        check("held_valid_bits", pat, 32'h0000AA13);

        // Reset in the middle of preamble bit 3.
        align(0);
        u_if.data_in = 8'hE7;
        u_if.data_valid = 1'b1;
        guard = 0;
        do begin tick(x); guard++; end while (!x && guard < 16);
        u_if.data_valid = 1'b0;
        strobes = int'(u_if.bit_strobe);
        guard = 0;
        while (strobes < 4 && guard < 40) begin
            tick(x);
            strobes += int'(u_if.bit_strobe);
            guard++;
        end
        tick(x);
        arst = 1'b1;
        tick(x);
        arst = 1'b0;
        check("rst_mid_outputs",
              {28'd0, u_if.mod_en, u_if.busy, u_if.bit_strobe, u_if.frame_done}, 32'd0);
        rpat = '0;
        for (int i = 0; i < 4; i++) begin
            rpat = {rpat[2:0], u_if.data_ready};
            tick(x);
        end
        check("rst_cnt_realigned_ready", {28'd0, rpat}, 32'h1);
        run_frame(8'h96, 8'h00, 1, en_cyc, pat, strobes, dones);
        check("post_rst_en_cycles", en_cyc, 64);
        check("post_rst_bits", pat, 32'h0000AA96);

        // One-bit preamble instance.
        u_if2.data_in = 8'h80;
        u_if2.data_valid = 1'b1;
        guard = 0;
        while (!u_if2.data_ready && guard < 8) begin tick(x); guard++; end
        if (!u_if2.data_ready) check("dut2_accept_timeout", 32'd0, 32'd1);
        tick(x);
        u_if2.data_valid = 1'b0;
        pat9 = '0; en_cyc = 0; dones = 0;
        for (int i = 0; i < 9 * SPB; i++) begin
            en_cyc += int'(u_if2.mod_en);
            dones  += int'(u_if2.frame_done);
            if (u_if2.bit_strobe) pat9 = {pat9[7:0], u_if2.mod_s};
            tick(x);
        end
        check("dut2_en_cycles", en_cyc, 36);
        check("dut2_bits", {23'd0, pat9}, 32'h180);
        check("dut2_end", {29'd0, u_if2.mod_en, u_if2.frame_done, 1'b0}, {29'd0, 1'b0, 1'b1, 1'b0});
        check("dut2_early_done", dones, 0);

        // Random traffic with occasional resets, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            arst = ($urandom_range(0, 999) == 0);
            if (!u_if.data_valid && $urandom_range(0, 7) == 0) begin
                u_if.data_in = 8'($urandom);
                u_if.data_valid = 1'b1;
            end
            tick(x);
            if (x) begin
                if ($urandom_range(0, 1) == 1) u_if.data_in = 8'($urandom);
                else                           u_if.data_valid = 1'b0;
            end
        end
        arst = 1'b0;
        u_if.data_valid = 1'b0;
        guard = 0;
        while ((m_active || u_if.mod_en) && guard < 2000) begin tick(x); guard++; end
        tick(x);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bpsk_tx_ctrl.md
# bpsk_tx_ctrl

Framing and symbol-timing controller for the BPSK modulator. Accepts bytes over a valid/ready handshake and prepends a fixed preamble to each frame. Serialises bits MSB first and drives the modulator's `en`/`s` inputs so that every bit lasts exactly one full carrier period. Bit changes land only on the carrier's wrap point, which keeps phase flips at zero crossings. Sits between the packet source and `bpsk_modulator`, sharing its clock and reset.

## Interface
- `ADDR_WIDTH`, 8: carrier table address width. Samples per bit = 2**`ADDR_WIDTH`. Must equal the modulator's `ADDR_WIDTH`.
- `PREAMBLE_LEN`, 8: number of preamble bits sent at the start of each frame (1..32).
- `PREAMBLE`, 32'hAAAAAAAA: preamble pattern. The low `PREAMBLE_LEN` bits are sent, MSB of that field first.

- `clk`  in  1  system clock, shared with modulator.
- `arst`  in  1  reset. Synchronous and active-high; sampled on `clk` rising edge. Same net as the modulator reset.
- `data_in`  in  8  byte to transmit.
- `data_valid`  in  1  `data_in` is valid. Must stay high, with `data_in` stable, until accepted.
- `data_ready`  out  1  controller accepts `data_in` this cycle. Combinational.
- `mod_en`  out  1  to modulator `en`. High while a frame is on air.
- `mod_s`  out  1  to modulator `s`. Current bit value.
- `busy`  out  1  state ≠ IDLE.
- `bit_strobe`  out  1  one-cycle pulse on the first sample of every transmitted bit.
- `frame_done`  out  1  one-cycle pulse on the first cycle after the last bit of a frame.

## Operation
- Sample counter `cnt` (`ADDR_WIDTH` bits):
  - Free-runs 0..2**`ADDR_WIDTH`-1 and wraps.
  - Reset to 0 by `arst`. This keeps it aligned with the sine tables' address counters.
  - `wrap` = (`cnt` == max).
- Handshake:
  - `data_ready` = `wrap` && (state == IDLE || (state == DATA && `bit_idx` == 7)).
  - Transfer occurs when `data_valid` && `data_ready`.
  - A byte is captured into shift register `sh`.
- FSM, all transitions evaluated only when `wrap`:
  - IDLE: on transfer → PRE, `pre_idx` = `PREAMBLE_LEN`-1. Otherwise stay.
  - PRE: `mod_s` = `PREAMBLE`[`pre_idx`].
    - When `pre_idx` == 0 → DATA, `bit_idx` = 0, `mod_s` = `sh`[7].
    - Otherwise decrement `pre_idx`.
  - DATA: `mod_s` = current bit, MSB first; `bit_idx` counts 0..7.
    - At `bit_idx` == 7 with a transfer → stay in DATA with the new byte. No preamble, no gap.
    - At `bit_idx` == 7 without a transfer → IDLE, `frame_done` pulses.
- `mod_en` = 1 in PRE and DATA, 0 in IDLE.
- `mod_s` holds its last value in IDLE; it is don't-care to the modulator while `en` = 0.
- `bit_strobe` = 1 when `cnt` == 0 and state ∈ {PRE, DATA}.
- `data_valid` arriving mid-bit is not accepted until the next `wrap`. The byte must be held.

## Timing
- Reset values: `cnt` = 0, state = IDLE, `mod_en` = 0, `mod_s` = 0, `busy` = 0, `bit_strobe` = 0, `frame_done` = 0, `sh` = 0. `data_ready` = 0 until `cnt` reaches max.
- `mod_en`, `mod_s`, `busy` and `frame_done` are registered and update on the edge after `wrap`. `cnt` == 0 is therefore always the first sample of a bit.
- Latency: transfer at cycle T (`cnt` == max) → `mod_en` = 1 and the first preamble bit at T+1.
- Each bit lasts exactly 2**`ADDR_WIDTH` cycles.
- Frame length = (`PREAMBLE_LEN` + 8·N)·2**`ADDR_WIDTH` cycles for N bytes sent back-to-back.
- `frame_done` pulses in the same cycle that `mod_en` falls.
- Reset mid-frame: next cycle all outputs are at reset values. The in-flight byte is dropped and no `frame_done` is issued.
- Reset takes priority over every other event, including a simultaneous transfer.

## Test plan
- `ADDR_WIDTH`=2, `PREAMBLE_LEN`=8, `PREAMBLE`=8'hAA. Reset for 3 cycles → all outputs 0. `data_ready` pulses high only when `cnt` == 3, with period 4.
- Single byte 0xC5, `data_valid` raised when `cnt` == 1 → accepted when `cnt` == 3 → `mod_en` high for 64 cycles. `mod_s` = 1,0,1,0,1,0,1,0 then 1,1,0,0,0,1,0,1, each held 4 cycles. 16 `bit_strobe` pulses. `frame_done` pulses once as `mod_en` falls.
- Back-to-back 0x00 then 0xFF, second `data_valid` held from mid-frame → second byte accepted at the bit-7 wrap of the first. Frame = 8+16 bits = 96 cycles with no gap and one preamble.
- `data_valid` held for 10 cycles in IDLE → exactly one transfer, at the first `wrap`. `data_in` is sampled at that edge.
- `arst` pulse during preamble bit 3 → next cycle `mod_en` = 0, `busy` = 0, `cnt` = 0, no `frame_done`. A subsequent byte still gets the full preamble.
- `PREAMBLE_LEN`=1, `PREAMBLE`=1 → frame for byte 0x80 = 9 bits: `mod_s` = 1,1,0,0,0,0,0,0,0.
